// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes, operator codes, FSM states and keypad decode table
package keypad_pkg;

    typedef enum logic [3:0] {
        K_0    = 4'd0,
        K_1    = 4'd1,
        K_2    = 4'd2,
        K_3    = 4'd3,
        K_4    = 4'd4,
        K_5    = 4'd5,
        K_6    = 4'd6,
        K_7    = 4'd7,
        K_8    = 4'd8,
        K_9    = 4'd9,
        K_A    = 4'd10,
        K_B    = 4'd11,
        K_C    = 4'd12,
        K_D    = 4'd13,
        K_STAR = 4'd14,
        K_HASH = 4'd15
    } key_t;

    typedef enum logic [1:0] {
        OP_A = 2'd0,
        OP_B = 2'd1,
        OP_C = 2'd2,
        OP_D = 2'd3
    } op_t;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_HELD     = 1'b1
    } press_state_t;

    localparam key_t KEY_STAR = K_STAR;
    localparam key_t KEY_HASH = K_HASH;

    // Row-major layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic key_t key_decode(input logic [1:0] row, input logic [1:0] col);
        key_t k;
        case ({row, col})
            4'h0:    k = K_1;
            4'h1:    k = K_2;
            4'h2:    k = K_3;
            4'h3:    k = K_A;
            4'h4:    k = K_4;
            4'h5:    k = K_5;
            4'h6:    k = K_6;
            4'h7:    k = K_B;
            4'h8:    k = K_7;
            4'h9:    k = K_8;
            4'hA:    k = K_9;
            4'hB:    k = K_C;
            4'hC:    k = KEY_STAR;
            4'hD:    k = K_0;
            4'hE:    k = KEY_HASH;
            default: k = K_D;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_press_filter.sv
// rtl/keypad_press_filter.sv - collapses repeated scanner events into one press per physical press
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid, row, col   scanner event stream
//   accept            combinational: this cycle's valid is a new press
//   press             one-cycle registered strobe, high after the accepting edge
//   press_row/col     row/col latched at the accepting edge
module keypad_press_filter
    import keypad_pkg::*;
#(
    parameter int RELEASE_CYCLES = 400_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [1:0] row,
    input  logic [1:0] col,
    output logic       accept,
    output logic       press,
    output logic [1:0] press_row,
    output logic [1:0] press_col
);

    localparam int CNT_W = $clog2(RELEASE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_CYCLES - 1);

    press_state_t     state;
    logic [CNT_W-1:0] rel_cnt;

    // The top loads its output registers from this at the same edge the
    // FSM leaves RELEASED, so entry/commit add no extra stage.
    assign accept = (state == ST_RELEASED) && valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RELEASED;
            rel_cnt   <= '0;
            press     <= 1'b0;
            press_row <= 2'd0;
            press_col <= 2'd0;
        end else begin
            press <= 1'b0;
            case (state)
                ST_RELEASED: begin
                    rel_cnt <= '0;
                    if (valid) begin
                        press     <= 1'b1;
                        press_row <= row;
                        press_col <= col;
                        state     <= ST_HELD;
                    end
                end
                default: begin
                    // valid beats expiry on the same edge; other keys are ignored
                    if (valid) begin
                        rel_cnt <= '0;
                    end else if (rel_cnt == CNT_LAST) begin
                        rel_cnt <= '0;
                        state   <= ST_RELEASED;
                    end else begin
                        rel_cnt <= rel_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad press decode, BCD operand entry/commit and operator events
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   row, col, valid       scanner event stream
//   key_pulse, key_code   one strobe per accepted press, code of last press
//   entry_bcd, entry_len  live operand (LS digit in [3:0]) and its digit count
//   num_valid, num_bcd    commit strobe and committed operand
//   op_valid, op_code     operator strobe and operator (A=0..D=3)
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int RELEASE_CYCLES = 400_000,
    parameter int N_DIGITS       = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   row,
    input  logic [1:0]                   col,
    input  logic                         valid,
    output logic                         key_pulse,
    output logic [3:0]                   key_code,
    output logic [4*N_DIGITS-1:0]        entry_bcd,
    output logic [$clog2(N_DIGITS+1)-1:0] entry_len,
    output logic                         num_valid,
    output logic [4*N_DIGITS-1:0]        num_bcd,
    output logic                         op_valid,
    output logic [1:0]                   op_code
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int LEN_W = $clog2(N_DIGITS + 1);

    logic       accept;
    logic [1:0] press_row;
    logic [1:0] press_col;
    logic       key_seen;
    key_t       key_now;
    op_t        op_now;
    logic [BCD_W-1:0] entry_shift;

    keypad_press_filter #(
        .RELEASE_CYCLES(RELEASE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .row      (row),
        .col      (col),
        .accept   (accept),
        .press    (key_pulse),
        .press_row(press_row),
        .press_col(press_col)
    );

    // key_code is a decode of the filter's latched row/col; key_seen keeps it
    // at 0 out of reset, since row0/col0 decodes to '1'.
    assign key_code = key_seen ? key_decode(press_row, press_col) : 4'd0;

    assign key_now     = key_decode(row, col);
    assign entry_shift = (entry_bcd << 4) | BCD_W'(key_now);

    always_comb begin
        op_now = OP_A;
        case (key_now)
            K_B:     op_now = OP_B;
            K_C:     op_now = OP_C;
            K_D:     op_now = OP_D;
            default: op_now = OP_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_seen  <= 1'b0;
            entry_bcd <= '0;
            entry_len <= '0;
            num_valid <= 1'b0;
            num_bcd   <= '0;
            op_valid  <= 1'b0;
            op_code   <= 2'd0;
        end else begin
            num_valid <= 1'b0;
            op_valid  <= 1'b0;
            if (accept) begin
                key_seen <= 1'b1;
                if (key_now < K_A) begin
                    if (entry_len < LEN_W'(N_DIGITS)) begin
                        entry_bcd <= entry_shift;
                        entry_len <= entry_len + LEN_W'(1);
                    end
                end else if (key_now == KEY_STAR) begin
                    entry_bcd <= '0;
                    entry_len <= '0;
                end else if (key_now == KEY_HASH) begin
                    if (entry_len != '0) begin
                        num_bcd   <= entry_bcd;
                        num_valid <= 1'b1;
                        entry_bcd <= '0;
                        entry_len <= '0;
                    end
                end else begin
                    op_code  <= op_now;
                    op_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - randomized and directed self-checking bench for keypad_entry
module tb_keypad_entry;

    localparam int RC = 8;
    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [1:0]  row = 2'd0;
    logic [1:0]  col = 2'd0;
    logic        key_pulse;
    logic [3:0]  key_code;
    logic [11:0] entry_bcd;
    logic [1:0]  entry_len;
    logic        num_valid;
    logic [11:0] num_bcd;
    logic        op_valid;
    logic [1:0]  op_code;

    keypad_entry #(.RELEASE_CYCLES(RC), .N_DIGITS(ND)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .valid    (valid),
        .key_pulse(key_pulse),
        .key_code (key_code),
        .entry_bcd(entry_bcd),
        .entry_len(entry_len),
        .num_valid(num_valid),
        .num_bcd  (num_bcd),
        .op_valid (op_valid),
        .op_code  (op_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: press accepted when idle or when more than RC cycles
    // have passed since the previous valid of the held key
    int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    int t = 0;
    bit held;
    int last_v;
    int q[$];
    int m_num, m_code, m_op;
    bit m_kp, m_nv, m_ov;
    int pulses = 0;
    int commits = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, t, got, exp);
        end
    endtask

    function automatic int q_bcd();
        int b = 0;
        foreach (q[i]) b = (b << 4) | q[i];
        return b;
    endfunction

    task automatic model_reset();
        held = 0; q.delete();
        m_num = 0; m_code = 0; m_op = 0;
        m_kp = 0; m_nv = 0; m_ov = 0;
    endtask

    task automatic model_edge(input bit v, input int idx);
        int k;
        m_kp = 0; m_nv = 0; m_ov = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (v) begin
            if (!held || (t - last_v) > RC) begin
                k = keymap[idx];
                m_kp = 1; m_code = k;
                if (k < 10) begin
                    if (q.size() < ND) q.push_back(k);
                end else if (k == 14) begin
                    q.delete();
                end else if (k == 15) begin
                    if (q.size() > 0) begin
                        m_num = q_bcd(); m_nv = 1; q.delete();
                    end
                end else begin
                    m_op = k - 10; m_ov = 1;
                end
            end
            held = 1; last_v = t;
        end
    endtask

    task automatic compare_all();
        check("key_pulse", key_pulse, m_kp);
        check("key_code",  key_code,  m_code);
        check("entry_bcd", entry_bcd, q_bcd());
        check("entry_len", entry_len, q.size());
        check("num_valid", num_valid, m_nv);
        check("num_bcd",   num_bcd,   m_num);
        check("op_valid",  op_valid,  m_ov);
        check("op_code",   op_code,   m_op);
    endtask

    task automatic step(input logic v, input logic [1:0] r, input logic [1:0] c);
        valid = v; row = r; col = c;
        @(posedge clk);
        #1;
        t++;
        model_edge(v, int'(r) * 4 + int'(c));
        if (key_pulse) pulses++;
        if (num_valid) commits++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 2'd0);
    endtask

    initial begin
        int p0, c0;
        model_reset();
        rst_n = 1'b0;
        idle(3);
        check("reset key_code", key_code, 0);
        check("reset entry_bcd", entry_bcd, 0);
        rst_n = 1'b1;
        idle(2);

        // one physical press with repeated scans, then a second press after release
        p0 = pulses;
        step(1'b1, 2'd1, 2'd2);
        check("held code", key_code, 6);
        for (int i = 0; i < 3; i++) begin
            idle(3);
            step(1'b1, 2'd1, 2'd2);
        end
        check("one pulse per press", pulses - p0, 1);
        idle(17);
        step(1'b1, 2'd1, 2'd2);
        check("second press", pulses - p0, 2);

        // release boundary
        idle(RC + 1);
        step(1'b1, 2'd0, 2'd0);
        idle(RC - 2);
        step(1'b1, 2'd0, 2'd0);
        check("valid before expiry", key_pulse, 0);
        idle(RC - 1);
        step(1'b1, 2'd0, 2'd0);
        check("valid at expiry edge", key_pulse, 0);
        idle(9);
        step(1'b1, 2'd0, 2'd0);
        check("press after gap", key_pulse, 1);
        idle(RC + 1);

        // entry and commit: 1 2 3 4 #
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
        c0 = commits;
        step(1'b1, 2'd0, 2'd0); check("entry 1", entry_bcd, 12'h001); idle(RC + 1);
        step(1'b1, 2'd0, 2'd1); check("entry 12", entry_bcd, 12'h012); idle(RC + 1);
        step(1'b1, 2'd0, 2'd2); check("entry 123", entry_bcd, 12'h123); idle(RC + 1);
        step(1'b1, 2'd1, 2'd0); check("entry full", entry_bcd, 12'h123);
        check("full still pulses", key_pulse, 1); idle(RC + 1);
        step(1'b1, 2'd3, 2'd2);
        check("commit num_bcd", num_bcd, 12'h123);
        check("commit len", entry_len, 0);
        idle(RC + 1);
        check("single commit", commits - c0, 1);

        // clear then empty commit, then operator C
        c0 = commits;
        step(1'b1, 2'd2, 2'd0); idle(RC + 1);
        step(1'b1, 2'd3, 2'd0); idle(RC + 1);
        step(1'b1, 2'd3, 2'd2);
        check("cleared entry", entry_bcd, 0);
        idle(RC + 1);
        check("empty commit", commits - c0, 0);
        step(1'b1, 2'd2, 2'd3);
        check("op_valid C", op_valid, 1);
        check("op_code C", op_code, 2);
        idle(RC + 1);

        // reset while held with entry 0x045
        step(1'b1, 2'd3, 2'd0); idle(RC + 1);
        step(1'b1, 2'd1, 2'd0); idle(RC + 1);
        step(1'b1, 2'd1, 2'd1);
        idle(2);
        step(1'b1, 2'd1, 2'd1);
        check("pre-reset entry", entry_bcd, 12'h045);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async reset num_bcd", num_bcd, 0);
        idle(2);
        rst_n = 1'b1;
        step(1'b1, 2'd3, 2'd1);
        check("post-reset code", key_code, 0);
        check("post-reset len", entry_len, 1);
        idle(RC + 1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            if ($urandom_range(0, 4) == 0)
                step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            else
                idle(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
